// File: rtl/step_sequencer.sv
// Step sequencer: steps through 2**STEP_BITS steps per bar and 2**SEQ_BITS sequences,
// advancing on synchronised slow_clk ticks. Define SEQ_IMMEDIATE_EN to apply sequence changes at once.
module step_sequencer #(
  parameter int STEP_BITS = 4,
  parameter int SEQ_BITS  = 6
) (
  input  logic                          CLK_50,
  input  logic                          reset,
  input  logic                          slow_clk,
  input  logic                          pb_seq_up,
  input  logic                          pb_seq_dn,
  input  logic                          run,
  output logic [SEQ_BITS+STEP_BITS-1:0] rom_addr,
  output logic [SEQ_BITS-1:0]           seq_num,
  output logic [STEP_BITS-1:0]          step,
  output logic                          pending,
  output logic                          step_strobe,
  output logic                          bar_strobe
);

  localparam logic [0:0] ST_HOLD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic                          slow_meta_q, slow_sync_q, slow_prev_q;
  logic                          tick_q, tick_d;
  logic                          up_prev_q, dn_prev_q;
  logic [0:0]                    state_q, state_d;
  logic [STEP_BITS-1:0]          step_q, step_d;
  logic [SEQ_BITS-1:0]           seq_q, seq_d;
  logic [SEQ_BITS-1:0]           pend_seq_q, pend_seq_d;
  logic                          pending_q, pending_d;
  logic [SEQ_BITS+STEP_BITS-1:0] rom_addr_q, rom_addr_d;
  logic                          step_strobe_q, step_strobe_d;
  logic                          bar_strobe_q, bar_strobe_d;

  logic                          up_req, dn_req, req_valid;
  logic [SEQ_BITS-1:0]           req_seq;
  logic                          advance, wrap;

  // The tick is registered once more so a step lands three edges after slow_clk is first sampled high.
  assign tick_d    = slow_sync_q & ~slow_prev_q;
  assign up_req    = pb_seq_up & ~up_prev_q;
  assign dn_req    = pb_seq_dn & ~dn_prev_q;
  assign req_valid = up_req ^ dn_req;
  assign req_seq   = up_req ? pend_seq_q + 1'b1 : pend_seq_q - 1'b1;
  assign advance   = tick_q && (state_q == ST_RUN);
  assign wrap      = advance && (step_q == {STEP_BITS{1'b1}});

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    state_d       = run ? ST_RUN : ST_HOLD;
    step_d        = step_q;
    seq_d         = seq_q;
    pend_seq_d    = pend_seq_q;
    pending_d     = pending_q;
    step_strobe_d = 1'b0;
    bar_strobe_d  = 1'b0;

    if (advance) begin
      step_d        = step_q + 1'b1;
      step_strobe_d = 1'b1;
      bar_strobe_d  = wrap;
    end

`ifdef SEQ_IMMEDIATE_EN
    // A change restarts the bar at once; pend_seq simply shadows seq_num.
    if (req_valid) begin
      seq_d         = req_seq;
      step_d        = '0;
      step_strobe_d = 1'b0;
      bar_strobe_d  = 1'b1;
    end
    pend_seq_d = seq_d;
    pending_d  = 1'b0;
`else
    if (req_valid) begin
      pend_seq_d = req_seq;
      pending_d  = 1'b1;
    end
    // A request arriving with the wrapping tick is already folded into pend_seq_d.
    if (wrap && pending_d) begin
      seq_d     = pend_seq_d;
      pending_d = 1'b0;
    end
`endif

    rom_addr_d = {seq_d, step_d};
  end

  // NOTE: reset is synchronous and sampled only on CLK_50, so it sits inside the clocked branch.
  always_ff @(posedge CLK_50) begin
    if (reset) begin
      slow_meta_q   <= 1'b0;
      slow_sync_q   <= 1'b0;
      slow_prev_q   <= 1'b0;
      tick_q        <= 1'b0;
      up_prev_q     <= 1'b0;
      dn_prev_q     <= 1'b0;
      state_q       <= ST_HOLD;
      step_q        <= '0;
      seq_q         <= '0;
      pend_seq_q    <= '0;
      pending_q     <= 1'b0;
      rom_addr_q    <= '0;
      step_strobe_q <= 1'b0;
      bar_strobe_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      slow_meta_q   <= slow_clk;
      slow_sync_q   <= slow_meta_q;
      slow_prev_q   <= slow_sync_q;
      tick_q        <= tick_d;
      up_prev_q     <= pb_seq_up;
      dn_prev_q     <= pb_seq_dn;
      state_q       <= state_d;
      step_q        <= step_d;
      seq_q         <= seq_d;
      pend_seq_q    <= pend_seq_d;
      pending_q     <= pending_d;
      rom_addr_q    <= rom_addr_d;
      step_strobe_q <= step_strobe_d;
      bar_strobe_q  <= bar_strobe_d;
    end
  end

  assign rom_addr    = rom_addr_q;
  assign seq_num     = seq_q;
  assign step        = step_q;
  assign pending     = pending_q;
  assign step_strobe = step_strobe_q;
  assign bar_strobe  = bar_strobe_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Scoreboard bench for step_sequencer: a model pushes the expected {seq, step, bar} per accepted
// tick and a negedge monitor pops and compares on every step_strobe.
module tb_step_sequencer;

  logic       CLK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       slow_clk = 1'b0;
  logic       pb_seq_up = 1'b0;
  logic       pb_seq_dn = 1'b0;
  logic       run = 1'b0;
  logic [9:0] rom_addr;
  logic [5:0] seq_num;
  logic [3:0] step;
  logic       pending, step_strobe, bar_strobe;

  step_sequencer #(.STEP_BITS(4), .SEQ_BITS(6)) dut (
    .CLK_50(CLK_50), .reset(reset), .slow_clk(slow_clk), .pb_seq_up(pb_seq_up),
    .pb_seq_dn(pb_seq_dn), .run(run), .rom_addr(rom_addr), .seq_num(seq_num),
    .step(step), .pending(pending), .step_strobe(step_strobe), .bar_strobe(bar_strobe)
  );

  always #10 CLK_50 = ~CLK_50;

  typedef struct {
    logic [5:0] seq;
    logic [3:0] step;
    logic       bar;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   bar_count = 0;
  int   strobe_count = 0;

  logic [3:0] m_step = '0;
  logic [5:0] m_seq = '0;
  logic [5:0] m_pend = '0;
  logic       m_pending = 1'b0;
  logic       m_run = 1'b0;

  always @(negedge CLK_50) begin
    if (!reset && step_strobe === 1'b1) begin
      strobe_count++;
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL strobe_unexpected: step=%0d seq=%0d, required no strobe", step, seq_num);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({seq_num, step, rom_addr, bar_strobe} !== {e.seq, e.step, e.seq, e.step, e.bar}) begin
          tests_failed++;
          $display("FAIL scoreboard: seq=%0d step=%0d rom=%h bar=%b, required seq=%0d step=%0d rom=%h bar=%b",
                   seq_num, step, rom_addr, bar_strobe, e.seq, e.step, {e.seq, e.step}, e.bar);
        end
      end
    end
    if (!reset && bar_strobe === 1'b1) begin
      bar_count++;
`ifndef SEQ_IMMEDIATE_EN
      tests_run++;
      if (step_strobe !== 1'b1) begin
        tests_failed++;
        $display("FAIL bar_without_step: step_strobe=%b, required 1", step_strobe);
      end
`endif
    end
  end

  task automatic model_tick();
    exp_t e;
    m_step = m_step + 1'b1;
    e.bar  = (m_step == 4'd0);
    if (e.bar && m_pending) begin
      m_seq     = m_pend;
      m_pending = 1'b0;
    end
    e.seq  = m_seq;
    e.step = m_step;
    exp_q.push_back(e);
  endtask

  task automatic model_request(input bit up, input bit dn);
    if (up != dn) begin
`ifdef SEQ_IMMEDIATE_EN
      m_seq  = up ? m_seq + 1'b1 : m_seq - 1'b1;
      m_step = '0;
      m_pend = m_seq;
`else
      m_pend    = up ? m_pend + 1'b1 : m_pend - 1'b1;
      m_pending = 1'b1;
`endif
    end
  endtask

  task automatic set_run(input bit v);
    @(negedge CLK_50);
    run   = v;
    m_run = v;
    repeat (2) @(negedge CLK_50);
  endtask

  // One slow_clk pulse; optionally raise pb_seq_up so its request coincides with the tick.
  task automatic pulse(input bit up_at_tick);
    @(negedge CLK_50);
    slow_clk = 1'b1;
    repeat (3) @(posedge CLK_50);
    #1;
    tests_run++;
    if (step !== m_step) begin
      tests_failed++;
      $display("FAIL latency_early: step=%0d, required %0d", step, m_step);
    end
    if (up_at_tick) begin
      @(negedge CLK_50);
      pb_seq_up = 1'b1;
      model_request(1'b1, 1'b0);
    end
    if (m_run) model_tick();
    @(posedge CLK_50);
    #1;
    tests_run++;
    if (step !== m_step) begin
      tests_failed++;
      $display("FAIL latency_step: step=%0d, required %0d", step, m_step);
    end
    repeat (3) @(negedge CLK_50);
    slow_clk  = 1'b0;
    pb_seq_up = 1'b0;
    repeat (4) @(negedge CLK_50);
  endtask

  task automatic request(input bit up, input bit dn);
    @(negedge CLK_50);
    pb_seq_up = up;
    pb_seq_dn = dn;
    model_request(up, dn);
    @(posedge CLK_50);
    #1;
`ifdef SEQ_IMMEDIATE_EN
    if (up != dn) begin
      tests_run++;
      if ({seq_num, step, rom_addr, bar_strobe, pending} !== {m_seq, 4'd0, m_seq, 4'd0, 1'b1, 1'b0}) begin
        tests_failed++;
        $display("FAIL immediate_apply: seq=%0d step=%0d rom=%h bar=%b pend=%b, required seq=%0d step=0 bar=1 pend=0",
                 seq_num, step, rom_addr, bar_strobe, pending, m_seq);
      end
    end
`endif
    repeat (2) @(negedge CLK_50);
    pb_seq_up = 1'b0;
    pb_seq_dn = 1'b0;
    repeat (2) @(negedge CLK_50);
    tests_run++;
    if ({pending, seq_num} !== {m_pending, m_seq}) begin
      tests_failed++;
      $display("FAIL request_state: pending=%b seq=%0d, required pending=%b seq=%0d",
               pending, seq_num, m_pending, m_seq);
    end
  endtask

  // Reset is held while a tick and a request are both presented, so it must win over them.
  task automatic test_reset();
    @(negedge CLK_50);
    reset     = 1'b1;
    slow_clk  = 1'b1;
    pb_seq_up = 1'b1;
    repeat (3) @(negedge CLK_50);
    tests_run++;
    if ({step, seq_num, rom_addr, pending, step_strobe, bar_strobe} !== 24'd0) begin
      tests_failed++;
      $display("FAIL reset_state: step=%0d seq=%0d rom=%h pend=%b ss=%b bs=%b, required all 0",
               step, seq_num, rom_addr, pending, step_strobe, bar_strobe);
    end
    slow_clk  = 1'b0;
    pb_seq_up = 1'b0;
    repeat (3) @(negedge CLK_50);
    reset     = 1'b0;
    m_step    = '0;
    m_seq     = '0;
    m_pend    = '0;
    m_pending = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge CLK_50);
    tests_run++;
    if ({step, seq_num, pending} !== 11'd0) begin
      tests_failed++;
      $display("FAIL reset_release: step=%0d seq=%0d pend=%b, required 0", step, seq_num, pending);
    end
  endtask

  task automatic test_full_bar();
    int bars0;
    bars0 = bar_count;
    for (int i = 0; i < 16; i++) pulse(1'b0);
    tests_run++;
    if ({bar_count - bars0, rom_addr, step} !== {32'd1, 10'h000, 4'd0}) begin
      tests_failed++;
      $display("FAIL full_bar: bars=%0d rom=%h step=%0d, required bars=1 rom=000 step=0",
               bar_count - bars0, rom_addr, step);
    end
  endtask

  task automatic test_queued_up();
    for (int i = 0; i < 5; i++) pulse(1'b0);
    request(1'b1, 1'b0);
    tests_run++;
    if ({pending, seq_num, rom_addr} !== {1'b1, 6'd0, 10'h005}) begin
      tests_failed++;
      $display("FAIL queued_hold: pend=%b seq=%0d rom=%h, required pend=1 seq=0 rom=005",
               pending, seq_num, rom_addr);
    end
    for (int i = 0; i < 11; i++) pulse(1'b0);
    tests_run++;
    if ({pending, seq_num, rom_addr} !== {1'b0, 6'd1, 10'h010}) begin
      tests_failed++;
      $display("FAIL queued_apply: pend=%b seq=%0d rom=%h, required pend=0 seq=1 rom=010",
               pending, seq_num, rom_addr);
    end
  endtask

  task automatic test_reset_discard();
    for (int i = 0; i < 3; i++) pulse(1'b0);
    request(1'b1, 1'b0);
    test_reset();
    set_run(1'b1);
    pulse(1'b0);
    tests_run++;
    if ({step, seq_num, pending} !== {4'd1, 6'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_discard: step=%0d seq=%0d pend=%b, required step=1 seq=0 pend=0",
               step, seq_num, pending);
    end
  endtask

  task automatic test_down_wrap();
    request(1'b0, 1'b1);
    while (m_step != 4'd0) pulse(1'b0);
    tests_run++;
    if ({seq_num, rom_addr} !== {6'd63, 10'h3F0}) begin
      tests_failed++;
      $display("FAIL down_wrap: seq=%0d rom=%h, required seq=63 rom=3f0", seq_num, rom_addr);
    end
  endtask

  task automatic test_simultaneous();
    logic [5:0] seq0;
    seq0 = m_seq;
    request(1'b1, 1'b1);
    tests_run++;
    if ({pending, seq_num} !== {1'b0, seq0}) begin
      tests_failed++;
      $display("FAIL simultaneous: pend=%b seq=%0d, required pend=0 seq=%0d", pending, seq_num, seq0);
    end
  endtask

  task automatic test_hold();
    logic [3:0] step0;
    int         strobes0;
    for (int i = 0; i < 3; i++) pulse(1'b0);
    step0    = m_step;
    strobes0 = strobe_count;
    set_run(1'b0);
    for (int i = 0; i < 4; i++) pulse(1'b0);
    tests_run++;
    if ({step, strobe_count - strobes0} !== {step0, 32'd0}) begin
      tests_failed++;
      $display("FAIL hold: step=%0d strobes=%0d, required step=%0d strobes=0",
               step, strobe_count - strobes0, step0);
    end
    set_run(1'b1);
    pulse(1'b0);
    tests_run++;
    if (step !== step0 + 4'd1) begin
      tests_failed++;
      $display("FAIL hold_resume: step=%0d, required %0d", step, step0 + 4'd1);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] seq0;
    seq0 = m_seq;
    request(1'b1, 1'b0);
    request(1'b0, 1'b1);
    tests_run++;
    if ({pending, seq_num} !== {1'b1, seq0}) begin
      tests_failed++;
      $display("FAIL net_zero_pending: pend=%b seq=%0d, required pend=1 seq=%0d", pending, seq_num, seq0);
    end
    while (m_step != 4'd0) pulse(1'b0);
    tests_run++;
    if ({pending, seq_num} !== {1'b0, seq0}) begin
      tests_failed++;
      $display("FAIL net_zero_apply: pend=%b seq=%0d, required pend=0 seq=%0d", pending, seq_num, seq0);
    end
    request(1'b1, 1'b0);
    request(1'b1, 1'b0);
    while (m_step != 4'd15) pulse(1'b0);
    pulse(1'b1);
    tests_run++;
    if ({pending, seq_num, rom_addr} !== {1'b0, 6'd2, 10'h020}) begin
      tests_failed++;
      $display("FAIL request_at_wrap: pend=%b seq=%0d rom=%h, required pend=0 seq=2 rom=020",
               pending, seq_num, rom_addr);
    end
  endtask

  task automatic test_immediate();
    for (int i = 0; i < 9; i++) pulse(1'b0);
    request(1'b1, 1'b0);
    tests_run++;
    if ({seq_num, step, rom_addr} !== {6'd1, 4'd0, 10'h010}) begin
      tests_failed++;
      $display("FAIL immediate_up: seq=%0d step=%0d rom=%h, required seq=1 step=0 rom=010",
               seq_num, step, rom_addr);
    end
    pulse(1'b0);
    tests_run++;
    if (rom_addr !== 10'h011) begin
      tests_failed++;
      $display("FAIL immediate_next: rom=%h, required 011", rom_addr);
    end
    request(1'b0, 1'b1);
    request(1'b0, 1'b1);
    tests_run++;
    if ({seq_num, rom_addr} !== {6'd63, 10'h3F0}) begin
      tests_failed++;
      $display("FAIL immediate_down: seq=%0d rom=%h, required seq=63 rom=3f0", seq_num, rom_addr);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    set_run(1'b1);
`ifdef SEQ_IMMEDIATE_EN
    test_immediate();
    test_simultaneous();
    test_hold();
`else
    test_full_bar();
    test_queued_up();
    test_reset_discard();
    test_down_wrap();
    test_simultaneous();
    test_hold();
    test_back_to_back();
`endif
    repeat (4) @(negedge CLK_50);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/step_sequencer.md
STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 SHALL have parameter STEP_BITS, default 4: step index width; 2**STEP_BITS steps per bar.
REQ-002 SHALL have parameter SEQ_BITS, default 6: sequence index width; 2**SEQ_BITS sequences.
REQ-003 SHALL use one clock and a synchronous, active-high reset: CLK_50 clocks every flop; reset is sampled only on CLK_50 rising edges.
REQ-004 SHALL have the ports below, clock and reset first:
  CLK_50  in  1  system clock, 50 MHz
  reset  in  1  synchronous, active-high reset
  slow_clk  in  1  tempo signal from throttle; treated as data, never used as a clock
  pb_seq_up  in  1  debounced level; a rising edge requests the next sequence
  pb_seq_dn  in  1  debounced level; a rising edge requests the previous sequence
  run  in  1  level; 1 = advance steps, 0 = hold
  rom_addr  out  SEQ_BITS+STEP_BITS  registered pattern ROM address, {seq_num, step}
  seq_num  out  SEQ_BITS  active sequence
  step  out  STEP_BITS  current step within the bar
  pending  out  1  a sequence change is queued
  step_strobe  out  1  one-cycle pulse when step advances
  bar_strobe  out  1  one-cycle pulse when step wraps to 0

Function
REQ-005 SHALL pass slow_clk through a 2-flop synchronizer plus an edge register; a tick is the cycle in which the synchronized value is 1 and the previous value was 0.
REQ-006 SHALL edge-detect pb_seq_up and pb_seq_dn with one register each; a request is the cycle in which the input is 1 and the registered copy is 0.
REQ-007 SHALL implement FSM states HOLD and RUN: HOLD->RUN when run=1; RUN->HOLD when run=0; the state change takes effect on the next cycle.
REQ-008 SHALL, on a tick in RUN, set step to step+1 modulo 2**STEP_BITS and pulse step_strobe in the cycle the new step is visible.
REQ-009 SHALL ignore ticks in HOLD; step and seq_num hold their values.
REQ-010 SHALL make step visible exactly 3 CLK_50 cycles after the first rising edge at which slow_clk is sampled high.
REQ-011 SHALL pulse bar_strobe, together with step_strobe, when step wraps from 2**STEP_BITS-1 to 0.
REQ-012 SHALL, on an up request, set pend_seq to pend_seq+1 modulo 2**SEQ_BITS and set pending=1; a down request does the same with pend_seq-1.
REQ-013 SHALL treat an up request and a down request in the same cycle as no request.
REQ-014 SHALL allow multiple queued requests to accumulate in pend_seq; a net return to seq_num still leaves pending=1 until it is applied.
REQ-015 SHALL, on a wrapping tick with pending=1, load seq_num from pend_seq and clear pending in that same cycle.
REQ-016 SHALL, when a request and a wrapping tick occur in the same cycle, include the request in the pend_seq value that is applied.
REQ-017 SHALL register rom_addr from the next-state seq_num and step, so that rom_addr always equals {seq_num, step} with zero skew.
REQ-018 SHALL make all outputs registered, with no combinational input-to-output path.

Reset
REQ-019 SHALL, while reset=1, force: step=0, seq_num=0, pend_seq=0, pending=0, rom_addr=0, step_strobe=0, bar_strobe=0, FSM=HOLD, synchronizer and edge registers=0.
REQ-020 SHALL let reset asserted mid-bar or with a change pending discard the pending request; the first tick after release that is accepted in RUN yields step=1.
REQ-021 SHALL give reset priority over ticks and requests in the same cycle.

Configuration
REQ-022 SHALL, when macro SEQ_IMMEDIATE_EN is defined, apply a sequence request in the cycle after it is detected: seq_num updates, step=0, and bar_strobe pulses; pending stays 0.
REQ-023 SHALL, when SEQ_IMMEDIATE_EN is undefined, use the queued bar-boundary behaviour of REQ-012 to REQ-016.

Verification
REQ-024 SHALL cover: reset, run=1, 16 slow_clk pulses -> step goes 1..15 then 0, one bar_strobe, rom_addr=0x000 at the wrap.
REQ-025 SHALL cover: at step 5, one pb_seq_up pulse -> pending=1 and seq_num=0 until the wrap; then seq_num=1 and rom_addr=0x010.
REQ-026 SHALL cover: seq_num=0, one pb_seq_dn pulse, then a wrap -> seq_num=63 and rom_addr=0x3F0.
REQ-027 SHALL cover: pb_seq_up and pb_seq_dn rising in the same cycle -> pending stays 0 and seq_num is unchanged.
REQ-028 SHALL cover: run=0 with 4 slow_clk pulses -> step unchanged and no strobes; then run=1 with 1 pulse -> step+1.
REQ-029 SHALL cover: with SEQ_IMMEDIATE_EN defined, pb_seq_up at step 9 -> seq_num=1, step=0, and rom_addr=0x010 within 2 cycles.
